airisc_wb_ahb_bridge: RTL and testbench
=======================================

// Module: airisc_wb_ahb_bridge
// PURPOSE
//  Wishbone-classic slave to AHB-Lite (HASTI) master bridge between the Caravel management WB port and the AIRISC memory subsystem.
//  Lets firmware on the management SoC preload and inspect the core's IMEM/DMEM through the memories' AHB-Lite ports.
//  One outstanding transfer at a time; non-burst (SINGLE) only.
//  Bus-error and timeout handling always ack the WB master, so it never hangs.
// PARAMETERS
//  BASE_ADDR  32'h3000_0000  WB window base; claimed when (wbs_adr_i & ADDR_MASK) == BASE_ADDR
//  ADDR_MASK  32'hFF00_0000  window mask; unmasked bits pass through to haddr
//  TIMEOUT    255            max hready-low cycles per AHB phase before forced error completion (1..1023)
//  ERR_DATA   32'hDEAD_BEEF  read data returned on error/timeout
// PORTS
//  wb_clk_i   in   1   clock; everything on rising edge
//  wb_rst_i   in   1   asynchronous, active-high reset
//  wbs_cyc_i  in   1   WB cycle
//  wbs_stb_i  in   1   WB strobe
//  wbs_we_i   in   1   WB write enable
//  wbs_sel_i  in   4   WB byte selects
//  wbs_adr_i  in   32  WB byte address
//  wbs_dat_i  in   32  WB write data
//  wbs_ack_o  out  1   WB acknowledge, one-cycle pulse
//  wbs_dat_o  out  32  WB read data, valid while wbs_ack_o=1
//  haddr      out  32  AHB address
//  hwrite     out  1   AHB write
//  hsize      out  3   AHB size: 0 byte, 1 half, 2 word
//  hburst     out  3   tied 3'b000 (SINGLE)
//  hmastlock  out  1   tied 0
//  hprot      out  4   tied 4'b0011 (data, privileged)
//  htrans     out  2   AHB transfer type: 2'b00 IDLE, 2'b10 NONSEQ
//  hwdata     out  32  AHB write data, driven in data phase
//  hrdata     in   32  AHB read data
//  hready     in   1   AHB ready
//  hresp      in   1   AHB response: 0 OKAY, 1 ERROR
//  err_clr_i  in   1   clears err_o
//  err_o      out  1   sticky: an error or timeout has occurred
//  busy_o     out  1   FSM not IDLE
// BEHAVIOUR
//  Reset (async): state IDLE; every output 0 except hprot=4'b0011; timeout counter 0.
//  FSM states:
//   IDLE: if cyc&stb&in-window, register haddr/hwrite/hsize/wdata, htrans<=NONSEQ, go ADDR.
//         Out-of-window requests are ignored (no ack).
//   ADDR: when hready=1, htrans<=IDLE, hwdata<=wdata, go DATA.
//   DATA: when hready=1 and hresp=0, capture hrdata (reads only), go ACK.
//         When hresp=1 (either cycle of the ERROR response), capture ERR_DATA, set err_o, go ACK;
//         htrans is already IDLE.
//   ACK:  wbs_ack_o=1 for exactly this cycle, then go IDLE.
//         A stb held high in the following IDLE cycle starts a new transfer.
//  Size/offset from wbs_sel_i:
//   1111 -> word, offset 0.
//   0011 -> half, offset 0.  1100 -> half, offset 2.
//   Single bit k -> byte, offset k.
//   Any other pattern -> word, offset 0.
//   haddr = {wbs_adr_i[31:2], offset}.
//  Latency with hready=1 throughout: stb sampled cycle 0 -> ack high in cycle 3 (4-cycle transfer).
//  Timeout: counter resets on each phase entry and increments per hready=0 cycle in ADDR/DATA.
//   On reaching TIMEOUT: htrans<=IDLE, data=ERR_DATA, err_o<=1, go ACK.
//  WB abort (cyc or stb drops in ADDR/DATA): the AHB transfer still completes; ACK is skipped (go IDLE).
//  err_o: set on error/timeout. err_clr_i clears it; a set event in the same cycle wins over clear.
//  wbs_dat_o holds its last value outside ack; on writes it returns 0.
// TESTING
//  1. Word write adr 0x3000_0010, dat 0x1234_5678, sel 1111, hready=1
//     -> NONSEQ haddr=0x0000_0010, hsize=2, hwdata=0x1234_5678 next cycle; ack in cycle 3.
//  2. Byte read sel 0100 adr 0x3000_0020, slave inserts 2 wait states
//     -> haddr=0x0000_0022, hsize=0; ack 2 cycles later than case 1; wbs_dat_o=hrdata.
//  3. Read with hresp=1 for 2 cycles -> ack with wbs_dat_o=0xDEAD_BEEF, err_o=1; err_clr_i pulse -> err_o=0.
//  4. hready stuck 0, TIMEOUT=8 -> after 8 stall cycles ack with 0xDEAD_BEEF, err_o=1, htrans=IDLE.
//  5. Access at 0x2000_0000 -> no htrans activity, no ack, busy_o=0.
//  6. Assert wb_rst_i mid-DATA -> all outputs immediately at reset values; the next transfer after release completes normally.

Source files
------------

// File: rtl/airisc_wb_ahb_bridge.sv
// airisc_wb_ahb_bridge: Wishbone-classic slave to AHB-Lite single-transfer master bridge
// with error/timeout completion so the WB master is always acknowledged.
module airisc_wb_ahb_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFF00_0000,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic        hmastlock,
    output logic [3:0]  hprot,
    output logic [1:0]  htrans,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp,
    input  logic        err_clr_i,
    output logic        err_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;
    state_t state, next_state;
    logic [9:0]  cnt;
    logic [31:0] wdata;
    logic        abort, wb_req, hit, in_phase, timed_out, fail, done, abort_now;
    logic [2:0]  size;
    logic [1:0]  off;

    assign hburst    = 3'b000;
    assign hmastlock = 1'b0;
    assign hprot     = 4'b0011;
    assign wbs_ack_o = state == ACK;
    assign busy_o    = state != IDLE;

    assign wb_req    = wbs_cyc_i & wbs_stb_i;
    assign hit       = wb_req && ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign in_phase  = state == ADDR || state == DATA;
    assign timed_out = in_phase && !hready && cnt == 10'(TIMEOUT - 1);
    // an ERROR response ends the data phase on its first cycle, whatever hready says
    assign fail      = (state == DATA && hresp) || timed_out;
    assign done      = fail || (state == DATA && hready);
    assign abort_now = abort || !wb_req;

    always_comb begin
        size = 3'd2;
        off  = 2'd0;
        case (wbs_sel_i)
            4'b0011: size = 3'd1;
            4'b1100: begin size = 3'd1; off = 2'd2; end
            4'b0001: size = 3'd0;
            4'b0010: begin size = 3'd0; off = 2'd1; end
            4'b0100: begin size = 3'd0; off = 2'd2; end
            4'b1000: begin size = 3'd0; off = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = hit ? ADDR : IDLE;
            ADDR: next_state = timed_out ? (abort_now ? IDLE : ACK) : hready ? DATA : ADDR;
            DATA: next_state = done ? (abort_now ? IDLE : ACK) : DATA;
            ACK:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) state <= IDLE;
        else          state <= next_state;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt       <= '0;
            wdata     <= '0;
            abort     <= 1'b0;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hsize     <= '0;
            htrans    <= 2'b00;
            hwdata    <= '0;
            wbs_dat_o <= '0;
            err_o     <= 1'b0;
        end else begin
            cnt <= (state != next_state) ? '0 : (in_phase && !hready) ? cnt + 10'd1 : cnt;
            if (state == IDLE && hit) begin
                haddr  <= (wbs_adr_i & ~ADDR_MASK & 32'hFFFF_FFFC) | {30'd0, off};
                hwrite <= wbs_we_i;
                hsize  <= size;
                wdata  <= wbs_dat_i;
                htrans <= 2'b10;
                abort  <= 1'b0;
            end else if (in_phase && !wb_req) begin
                abort <= 1'b1;
            end
            if (state == ADDR && (hready || timed_out)) htrans <= 2'b00;
            if (state == ADDR && hready) hwdata <= wdata;
            if (done) wbs_dat_o <= fail ? ERR_DATA : hwrite ? 32'd0 : hrdata;
            err_o <= fail ? 1'b1 : err_clr_i ? 1'b0 : err_o;
        end
    end
endmodule

// File: tb/tb_airisc_wb_ahb_bridge.sv
// tb_airisc_wb_ahb_bridge: directed vectors against hand-computed bus behaviour
// of the WB-to-AHB bridge, including waits, errors, timeout, window miss and reset.
module tb_airisc_wb_ahb_bridge;
    logic        clk = 0, rst = 1;
    logic        cyc = 0, stb = 0, we = 0;
    logic [3:0]  sel = 0;
    logic [31:0] adr = 0, dat = 0;
    logic        ack;
    logic [31:0] dat_o, haddr, hwdata, hrdata = 0;
    logic        hwrite, hmastlock, hready = 1, hresp = 0, err_clr = 0, err, busy;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    int          n_vec = 0, n_bad = 0;

    airisc_wb_ahb_bridge #(.TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .err_clr_i(err_clr), .err_o(err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
    endtask

    task automatic drop();
        cyc = 0; stb = 0;
    endtask

    initial begin
        tick(2);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_hprot", 32'(hprot), 32'h3);
        chk("rst_htrans", 32'(htrans), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_misc", {hburst, hmastlock, err, hsize}, 0);
        rst = 0;
        tick(1);

        // 1: word write, zero wait states
        start(1, 32'h3000_0010, 32'h1234_5678, 4'b1111);
        tick();
        chk("w_htrans", 32'(htrans), 32'h2);
        chk("w_haddr", haddr, 32'h0000_0010);
        chk("w_hsize", 32'(hsize), 2);
        chk("w_hwrite", 32'(hwrite), 1);
        tick();
        chk("w_htrans_d", 32'(htrans), 0);
        chk("w_hwdata", hwdata, 32'h1234_5678);
        chk("w_ack_early", 32'(ack), 0);
        tick();
        chk("w_ack", 32'(ack), 1);
        chk("w_dat", dat_o, 0);
        drop();
        tick();
        chk("w_ack_pulse", 32'(ack), 0);
        chk("w_idle", 32'(busy), 0);

        // 2: byte read, two wait states in the data phase
        start(0, 32'h3000_0020, 0, 4'b0100);
        tick();
        chk("r_haddr", haddr, 32'h0000_0022);
        chk("r_hsize", 32'(hsize), 0);
        tick();
        hready = 0;
        tick(2);
        chk("r_wait_ack", 32'(ack), 0);
        chk("r_wait_busy", 32'(busy), 1);
        hready = 1; hrdata = 32'hCAFE_F00D;
        tick();
        chk("r_ack", 32'(ack), 1);
        chk("r_dat", dat_o, 32'hCAFE_F00D);
        chk("r_err", 32'(err), 0);
        drop();
        tick();

        // 3: read with two-cycle ERROR response
        start(0, 32'h3000_0004, 0, 4'b1111);
        tick(2);
        hresp = 1; hready = 0;
        tick();
        hready = 1;
        chk("e_ack", 32'(ack), 1);
        chk("e_dat", dat_o, 32'hDEAD_BEEF);
        chk("e_err", 32'(err), 1);
        drop();
        tick();
        hresp = 0;
        chk("e_sticky", 32'(err), 1);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("e_clr", 32'(err), 0);

        // 4: timeout in the address phase; clear held high loses to the set
        start(0, 32'h3000_0008, 0, 4'b1111);
        hready = 0; err_clr = 1;
        tick(8);
        chk("t_wait_ack", 32'(ack), 0);
        chk("t_wait_htrans", 32'(htrans), 32'h2);
        tick();
        chk("t_ack", 32'(ack), 1);
        chk("t_dat", dat_o, 32'hDEAD_BEEF);
        chk("t_err", 32'(err), 1);
        chk("t_htrans", 32'(htrans), 0);
        drop();
        hready = 1;
        tick();
        chk("t_clr", 32'(err), 0);
        err_clr = 0;

        // 5: out-of-window access is ignored
        start(0, 32'h2000_0000, 0, 4'b1111);
        tick(3);
        chk("o_htrans", 32'(htrans), 0);
        chk("o_ack", 32'(ack), 0);
        chk("o_busy", 32'(busy), 0);
        drop();
        tick();

        // 6: reset asserted mid-DATA, then a half-word write completes normally
        start(1, 32'h3000_0040, 32'h0000_0055, 4'b1111);
        tick(2);
        chk("x_busy", 32'(busy), 1);
        rst = 1;
        #2;
        chk("x_busy_rst", 32'(busy), 0);
        chk("x_hwdata_rst", hwdata, 0);
        chk("x_haddr_rst", haddr, 0);
        chk("x_hprot_rst", 32'(hprot), 32'h3);
        drop();
        #1 rst = 0;
        tick();
        start(1, 32'h3000_0100, 32'hBEEF_0000, 4'b1100);
        tick();
        chk("h_haddr", haddr, 32'h0000_0102);
        chk("h_hsize", 32'(hsize), 1);
        tick(2);
        chk("h_ack", 32'(ack), 1);
        chk("h_hwdata", hwdata, 32'hBEEF_0000);
        drop();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
